pcds_param: RTL and testbench
=============================

# pcds_param

Parametrised payload constellation scrambler/descrambler for the OFDM payload path. It applies a per-sample quarter-turn rotation or negation, selected by a 13-bit two-output LFSR, over a configurable index window of each symbol. It supports runtime scramble or descramble mode, gapped input valid and explicit symbol-start realignment. It sits between the FFT/equaliser output and the demapper in RX, and before the IFFT in TX.

## Interface
Parameters:
- `DW`, 14: signed I/Q sample width.
- `N`, 512: samples per OFDM symbol.
- `START`, 16: first scrambled index (inclusive).
- `END`, 495: last scrambled index (inclusive). Legal range: 0 ≤ START ≤ END ≤ N-1.
- `SEED`, 13'h1FFF: LFSR load value. Bit order s[0:12], where s[0] is the MSB of the literal.

Ports:
- `clk`, input, 1: working clock.
- `rst_n`, input, 1: reset. Asynchronous assert, active-low.
- `di_re`, input, DW signed: input real part.
- `di_im`, input, DW signed: input imaginary part.
- `di_vld`, input, 1: input sample valid.
- `di_sof`, input, 1: current valid sample is index 0 of a symbol. Only meaningful with `di_vld`.
- `di_mode`, input, 1: 0 = descramble, 1 = scramble. Sampled per valid sample.
- `do_re`, output, DW signed: output real part.
- `do_im`, output, DW signed: output imaginary part.
- `do_vld`, output, 1: output valid.
- `do_sof`, output, 1: output sample is index 0.
- `do_idx`, output, clog2(N): index of the output sample.

## Operation
**Index counter `idx`.**
- Holds the index of the next valid sample. Reset value 0.
- On `di_vld`: the sample's index is 0 if `di_sof`, otherwise `idx`. `idx` then becomes (sample index + 1), wrapping from N-1 to 0.
- When `di_vld` is low, `idx` holds. Gaps do not disturb alignment.

**LFSR.**
- One step: s ← {f2, f1, s[0:10]}.
  - f1 = s7^s10^s11^s12
  - f2 = s6^s9^s10^s11
- Rotation code c = {s[0], s[1]} of the current state.
- At the sample with index START, the state equals SEED. Each subsequent in-window valid sample uses the state advanced by exactly one step.
- The LFSR advances only on valid in-window samples.
- The LFSR reloads SEED on reset, on any `di_sof`, and on the valid sample with index END. This also covers START = END.

**Code selection.** Outside the window [START, END], c = 00.

**Rotation (descramble, `di_mode` = 0):**
- 00: (re, im)
- 10: (im, −re)
- 01: (−re, −im)
- 11: (−im, re)

**Rotation (scramble, `di_mode` = 1):**
- Codes 10 and 11 swap, i.e. the rotation is conjugated.
- Codes 00 and 01 are unchanged.

**Arithmetic.** Negation is DW-bit two's complement. Behaviour for −2^(DW-1) is set under Configuration. There is no other width growth.

**Outputs.**
- Registered; update only on `di_vld`, otherwise hold their last value.
- `do_vld` is `di_vld` delayed by one cycle.
- `do_sof` and `do_idx` are registered with the data and updated only on `di_vld`.

## Timing
- Latency 1 cycle: the sample presented at edge k appears at edge k+1.
- Throughput: 1 sample/cycle; gaps of any length are allowed.
- Reset values: `do_re` = 0, `do_im` = 0, `do_vld` = 0, `do_sof` = 0, `do_idx` = 0, `idx` = 0, LFSR = SEED.
- Reset mid-symbol: outputs clear immediately, without waiting for a clock edge. The first valid sample after release is index 0.
- `di_sof` while `idx` ≠ 0: realign. The partial symbol is abandoned with no flag.
- `di_sof` at index 0: no effect beyond the normal behaviour.
- `di_sof` without `di_vld`: ignored.
- `di_mode` change mid-symbol: takes effect on that sample, with no LFSR disturbance.

## Configuration
- `PCDS_SAT_EN` defined: negating −2^(DW-1) yields 2^(DW-1)−1 (saturates). This applies to every negation path.
- Undefined: the result wraps to −2^(DW-1), e.g. −8192 stays −8192 for DW = 14.

## Test plan
1. Defaults, descramble, constant (100, 50) for 512 valid cycles:
   - indices 0–15 and 496–511 → (100, 50);
   - index 16 (c = 11) → (−50, 100);
   - indices 17 and 18 (c = 00) → (100, 50);
   - `do_sof` high only on index 0.
2. Round trip, random data for 4 symbols: scrambler instance (`di_mode` = 1) feeding a descrambler instance (`di_mode` = 0) → bit-exact input reproduced, 2-cycle latency.
3. `di_vld` toggling every other cycle for 2 symbols → data and `do_idx` sequence identical to the continuous run; `do_re`/`do_im` hold during gaps.
4. `di_sof` pulsed at `idx` = 200, then continuous data (100, 50) → `do_idx` restarts at 0; the sample at the new index 16 → (−50, 100).
5. SEED = 13'h0800, START = END = 0, input (−8192, 5) at index 0 (c = 01):
   - with `PCDS_SAT_EN` → (8191, −5);
   - without → (−8192, −5);
   - index 1 → passthrough.
6. `rst_n` low for 3 cycles at index 300 → all outputs 0 asynchronously. After release, `di_vld` without `di_sof` → `do_idx` = 0, 1, 2, and index 16 → c = 11.

Source files
------------

// File: rtl/pcds_param.sv
// Payload constellation scrambler/descrambler: LFSR-driven quarter-turn / negation over an index window.
// Optional define PCDS_SAT_EN: negating the most negative sample saturates instead of wrapping.
module pcds_param #(
    parameter int          DW    = 14,
    parameter int          N     = 512,
    parameter int          START = 16,
    parameter int          END   = 495,
    parameter logic [12:0] SEED  = 13'h1FFF,
    localparam int         IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] di_re,
    input  logic signed [DW-1:0] di_im,
    input  logic                 di_vld,
    input  logic                 di_sof,
    input  logic                 di_mode,
    output logic signed [DW-1:0] do_re,
    output logic signed [DW-1:0] do_im,
    output logic                 do_vld,
    output logic                 do_sof,
    output logic [IW-1:0]        do_idx
);

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } iq_t;

    localparam logic signed [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] MAX_VAL = {1'b0, {(DW-1){1'b1}}};

    function automatic logic signed [DW-1:0] neg(input logic signed [DW-1:0] x);
`ifdef PCDS_SAT_EN
        if (x == MIN_VAL) return MAX_VAL;
`endif
        return -x;
    endfunction

    // LFSR bit s[k] lives at lfsr[12-k], so the literal reads MSB-first as s[0..12].
    logic [12:0]   lfsr, lfsr_cur, lfsr_step, lfsr_nxt;
    logic [IW-1:0] idx, sidx, idx_nxt;
    logic          in_win;
    logic [1:0]    code;
    iq_t           rot;

    always_comb begin
        sidx      = di_sof ? '0 : idx;
        lfsr_cur  = di_sof ? SEED : lfsr;
        in_win    = (int'(sidx) >= START) && (int'(sidx) <= END);
        lfsr_step = {lfsr_cur[6] ^ lfsr_cur[3] ^ lfsr_cur[2] ^ lfsr_cur[1],
                     lfsr_cur[5] ^ lfsr_cur[2] ^ lfsr_cur[1] ^ lfsr_cur[0],
                     lfsr_cur[12:2]};
        idx_nxt   = (int'(sidx) == N - 1) ? '0 : sidx + 1'b1;

        if (int'(sidx) == END) lfsr_nxt = SEED;
        else if (in_win)       lfsr_nxt = lfsr_step;
        else                   lfsr_nxt = lfsr_cur;

        code = in_win ? lfsr_cur[12:11] : 2'b00;
        // Scrambling conjugates the rotation: quarter-turn codes trade places.
        if (di_mode) code = code ^ {1'b0, code[1]};

        rot = '{re: di_re, im: di_im};
        case (code)
            2'b10:   rot = '{re: di_im,      im: neg(di_re)};
            2'b01:   rot = '{re: neg(di_re), im: neg(di_im)};
            2'b11:   rot = '{re: neg(di_im), im: di_re};
            default: rot = '{re: di_re,      im: di_im};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            lfsr   <= SEED;
            do_re  <= '0;
            do_im  <= '0;
            do_vld <= 1'b0;
            do_sof <= 1'b0;
            do_idx <= '0;
        end else begin
            do_vld <= di_vld;
            if (di_vld) begin
                idx    <= idx_nxt;
                lfsr   <= lfsr_nxt;
                do_re  <= rot.re;
                do_im  <= rot.im;
                do_sof <= (sidx == '0);
                do_idx <= sidx;
            end
        end
    end

endmodule

// File: tb/tb_pcds_param.sv
// Directed bench for pcds_param: window edges, round trip, gaps, realign, negation corner, async reset.
module tb_pcds_param;

    localparam int DW = 14;
    localparam int N  = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // main instance (defaults)
    logic signed [DW-1:0] m_re, m_im, mo_re, mo_im;
    logic                 m_vld, m_sof, m_mode, mo_vld, mo_sof;
    logic [8:0]           mo_idx;

    pcds_param u_main (
        .clk(clk), .rst_n(rst_n), .di_re(m_re), .di_im(m_im), .di_vld(m_vld),
        .di_sof(m_sof), .di_mode(m_mode), .do_re(mo_re), .do_im(mo_im),
        .do_vld(mo_vld), .do_sof(mo_sof), .do_idx(mo_idx));

    // scrambler feeding descrambler
    logic signed [DW-1:0] s_re, s_im, so_re, so_im, d_re, d_im;
    logic                 s_vld, s_sof, so_vld, so_sof, d_vld, d_sof;
    logic [8:0]           so_idx, d_idx;

    pcds_param u_scr (
        .clk(clk), .rst_n(rst_n), .di_re(s_re), .di_im(s_im), .di_vld(s_vld),
        .di_sof(s_sof), .di_mode(1'b1), .do_re(so_re), .do_im(so_im),
        .do_vld(so_vld), .do_sof(so_sof), .do_idx(so_idx));

    pcds_param u_dsc (
        .clk(clk), .rst_n(rst_n), .di_re(so_re), .di_im(so_im), .di_vld(so_vld),
        .di_sof(so_sof), .di_mode(1'b0), .do_re(d_re), .do_im(d_im),
        .do_vld(d_vld), .do_sof(d_sof), .do_idx(d_idx));

    // single-index window, negation code at index 0
    logic signed [DW-1:0] t_re, t_im, to_re, to_im;
    logic                 t_vld, t_sof, to_vld, to_sof;
    logic [8:0]           to_idx;

    pcds_param #(.SEED(13'h0800), .START(0), .END(0)) u_t5 (
        .clk(clk), .rst_n(rst_n), .di_re(t_re), .di_im(t_im), .di_vld(t_vld),
        .di_sof(t_sof), .di_mode(1'b0), .do_re(to_re), .do_im(to_im),
        .do_vld(to_vld), .do_sof(to_sof), .do_idx(to_idx));

    int ref_re [N];
    int ref_im [N];
    int rt_re  [4*N];
    int rt_im  [4*N];

    task automatic step_main(input int re, input int im, input logic vld, input logic sof);
        m_re = DW'(re); m_im = DW'(im); m_vld = vld; m_sof = sof;
        @(posedge clk); #1;
        m_vld = 1'b0; m_sof = 1'b0;
    endtask

    initial begin
        int hold_re, hold_im, j;
        m_re = '0; m_im = '0; m_vld = 0; m_sof = 0; m_mode = 0;
        s_re = '0; s_im = '0; s_vld = 0; s_sof = 0;
        t_re = '0; t_im = '0; t_vld = 0; t_sof = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_re", mo_re, 0);
        chk("rst_im", mo_im, 0);
        chk("rst_vld", mo_vld, 0);
        chk("rst_sof", mo_sof, 0);
        chk("rst_idx", mo_idx, 0);
        rst_n = 1'b1;

        // 1: constant (100,50), one full symbol
        for (int i = 0; i < N; i++) begin
            step_main(100, 50, 1'b1, 1'b0);
            ref_re[i] = mo_re; ref_im[i] = mo_im;
            chk("t1_vld", mo_vld, 1);
            chk("t1_idx", mo_idx, i);
            chk("t1_sof", mo_sof, (i == 0) ? 1 : 0);
            if (i == 16) begin
                chk("t1_re16", mo_re, -50);
                chk("t1_im16", mo_im, 100);
            end else if (i < 19 || i > 495) begin
                chk("t1_re_pass", mo_re, 100);
                chk("t1_im_pass", mo_im, 50);
            end
        end

        // 3: valid every other cycle for two symbols
        for (int i = 0; i < 2 * N; i++) begin
            step_main(100, 50, 1'b1, 1'b0);
            chk("t3_idx", mo_idx, i % N);
            chk("t3_re", mo_re, ref_re[i % N]);
            chk("t3_im", mo_im, ref_im[i % N]);
            hold_re = mo_re; hold_im = mo_im;
            m_re = 14'sd77; m_im = -14'sd77;
            step_main(-1, -1, 1'b0, 1'b0);
            chk("t3_gap_vld", mo_vld, 0);
            chk("t3_gap_re", mo_re, hold_re);
            chk("t3_gap_im", mo_im, hold_im);
        end

        // 4: realign at idx 200
        for (int i = 0; i < 200; i++) step_main(100, 50, 1'b1, 1'b0);
        chk("t4_pre_idx", mo_idx, 199);
        step_main(100, 50, 1'b1, 1'b1);
        chk("t4_sof", mo_sof, 1);
        chk("t4_idx0", mo_idx, 0);
        for (j = 1; j < 300; j++) begin
            step_main(100, 50, 1'b1, 1'b0);
            chk("t4_idx", mo_idx, j);
            if (j == 16) begin
                chk("t4_re16", mo_re, -50);
                chk("t4_im16", mo_im, 100);
            end
        end

        // 6: async reset at index 300 (last output index 299)
        m_re = 14'sd100; m_im = 14'sd50; m_vld = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_re", mo_re, 0);
        chk("t6_im", mo_im, 0);
        chk("t6_vld", mo_vld, 0);
        chk("t6_sof", mo_sof, 0);
        chk("t6_idx", mo_idx, 0);
        m_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            step_main(100, 50, 1'b1, 1'b0);
            chk("t6_post_idx", mo_idx, i);
            if (i == 16) begin
                chk("t6_re16", mo_re, -50);
                chk("t6_im16", mo_im, 100);
            end
        end

        // 2: scramble -> descramble round trip, four symbols
        for (int k = 0; k < 4 * N; k++) begin
            rt_re[k] = int'($urandom_range(16382)) - 8191;
            rt_im[k] = int'($urandom_range(16382)) - 8191;
        end
        for (int k = 0; k <= 4 * N; k++) begin
            s_vld = (k < 4 * N);
            s_sof = (k < 4 * N) && (k % N == 0);
            s_re  = (k < 4 * N) ? DW'(rt_re[k]) : '0;
            s_im  = (k < 4 * N) ? DW'(rt_im[k]) : '0;
            @(posedge clk); #1;
            if (k >= 1) begin
                chk("t2_vld", d_vld, 1);
                chk("t2_re", d_re, rt_re[k-1]);
                chk("t2_im", d_im, rt_im[k-1]);
                chk("t2_idx", d_idx, (k - 1) % N);
            end
        end
        s_vld = 1'b0; s_sof = 1'b0;
        @(posedge clk); #1;
        chk("t2_tail_vld", d_vld, 0);

        // 5: most-negative real part under negation at index 0
        t_re = -14'sd8192; t_im = 14'sd5; t_vld = 1'b1; t_sof = 1'b1;
        @(posedge clk); #1;
`ifdef PCDS_SAT_EN
        chk("t5_re", to_re, 8191);
`else
        chk("t5_re", to_re, -8192);
`endif
        chk("t5_im", to_im, -5);
        chk("t5_idx", to_idx, 0);
        t_re = 14'sd7; t_im = -14'sd3; t_sof = 1'b0;
        @(posedge clk); #1;
        chk("t5_pass_re", to_re, 7);
        chk("t5_pass_im", to_im, -3);
        chk("t5_pass_idx", to_idx, 1);
        t_re = 14'sd9; t_im = 14'sd4; t_sof = 1'b1;
        @(posedge clk); #1;
        chk("t5_again_re", to_re, -9);
        chk("t5_again_im", to_im, -4);
        t_vld = 1'b0; t_sof = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
